one_bit_cmp: RTL and testbench

- Registered single-bit magnitude comparator: compares operand A against B and flags A>B, A==B, A<B as one-hot outputs.
- Cascade inputs allow chaining with higher-significance stages to build wider comparators, bit-serial or parallel.
- Leaf arithmetic primitive; used by the decimal-to-BCD datapath and any wider compare built from it.

---
 rtl/one_bit_cmp.sv | 97 +++++++++
 tb/tb_one_bit_cmp.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/one_bit_cmp.sv
// Registered single-bit magnitude comparator with cascade inputs for wider compares.
// Optional saturating per-class result counters when CMP_STATS_EN is defined.
module one_bit_cmp #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             A,
  input  logic             B,
  input  logic             casc_gt,
  input  logic             casc_eq,
  input  logic             casc_lt,
  output logic             Greater,
  output logic             Equal,
  output logic             Smaller,
`ifdef CMP_STATS_EN
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
`endif
  output logic             out_valid
);

  logic gt_l;
  logic eq_l;
  logic lt_l;
  logic gt_r;
  logic eq_r;
  logic lt_r;

  assign gt_l = A & ~B;
  assign lt_l = ~A & B;
  assign eq_l = ~(A ^ B);

  // Higher stages win; an undecided or all-zero cascade falls back to local
  always_comb begin
    gt_r = gt_l;
    eq_r = eq_l;
    lt_r = lt_l;
    priority case (1'b1)
      casc_gt: begin
        gt_r = 1'b1;
        eq_r = 1'b0;
        lt_r = 1'b0;
      end
      casc_lt: begin
        gt_r = 1'b0;
        eq_r = 1'b0;
        lt_r = 1'b1;
      end
      casc_eq: begin
        gt_r = gt_l;
        eq_r = eq_l;
        lt_r = lt_l;
      end
      default: begin
        gt_r = gt_l;
        eq_r = eq_l;
        lt_r = lt_l;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Greater   <= 1'b0;
      Equal     <= 1'b0;
      Smaller   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Greater <= gt_r;
        Equal   <= eq_r;
        Smaller <= lt_r;
      end
    end
  end

`ifdef CMP_STATS_EN
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      gt_cnt <= '0;
      eq_cnt <= '0;
      lt_cnt <= '0;
    end else if (in_valid) begin
      if (gt_r && gt_cnt != '1) gt_cnt <= gt_cnt + ONE;
      if (eq_r && eq_cnt != '1) eq_cnt <= eq_cnt + ONE;
      if (lt_r && lt_cnt != '1) lt_cnt <= lt_cnt + ONE;
    end
  end
`endif

endmodule

// File: tb/tb_one_bit_cmp.sv
// Self-checking bench for one_bit_cmp: directed vector table, random run
// against a reference model, and counter checks when CMP_STATS_EN is set.
module tb_one_bit_cmp;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic A;
  logic B;
  logic casc_gt;
  logic casc_eq;
  logic casc_lt;
  logic Greater;
  logic Equal;
  logic Smaller;
  logic out_valid;
`ifdef CMP_STATS_EN
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  one_bit_cmp #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .A(A),
    .B(B),
    .casc_gt(casc_gt),
    .casc_eq(casc_eq),
    .casc_lt(casc_lt),
    .Greater(Greater),
    .Equal(Equal),
    .Smaller(Smaller),
`ifdef CMP_STATS_EN
    .gt_cnt(gt_cnt),
    .eq_cnt(eq_cnt),
    .lt_cnt(lt_cnt),
`endif
    .out_valid(out_valid)
  );

  typedef struct {
    string name;
    logic  r;
    logic  v;
    logic  a;
    logic  b;
    logic  cg;
    logic  ce;
    logic  cl;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string n, input logic r, input logic v,
                     input logic a, input logic b, input logic cg,
                     input logic ce, input logic cl, input logic [3:0] e);
    vec_t t;
    t.name = n; t.r = r; t.v = v; t.a = a; t.b = b;
    t.cg = cg; t.ce = ce; t.cl = cl; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic apply(input logic r, input logic v, input logic a,
                       input logic b, input logic cg, input logic ce,
                       input logic cl);
    @(negedge clk);
    rst = r; in_valid = v; A = a; B = b;
    casc_gt = cg; casc_eq = ce; casc_lt = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [3:0] exp);
    logic [3:0] act;
    act = {Greater, Equal, Smaller, out_valid};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got G/E/S/V=%b want %b", n, act, exp);
    end
  endtask

  task automatic check_cnt(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  // Reference model: 0 = none yet, 1 = A<B, 2 = equal, 3 = A>B
  int m_res;
  int m_val;
  int m_cnt[4];

  function automatic int resolve(input logic a, input logic b,
                                 input logic cg, input logic cl);
    if (cg) return 3;
    if (cl) return 1;
    if (int'(a) > int'(b)) return 3;
    if (int'(a) < int'(b)) return 1;
    return 2;
  endfunction

  function automatic logic [3:0] model_out();
    logic [3:0] e;
    e = 4'b0000;
    if (m_res == 3) e[3] = 1'b1;
    if (m_res == 2) e[2] = 1'b1;
    if (m_res == 1) e[1] = 1'b1;
    e[0] = (m_val != 0);
    return e;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = 1'b0; B = 1'b0;
    casc_gt = 1'b0; casc_eq = 1'b1; casc_lt = 1'b0;

    add("reset0",   1, 0, 0, 0, 0, 1, 0, 4'b0000);
    add("reset1",   1, 0, 0, 0, 0, 1, 0, 4'b0000);
    add("eq00",     0, 1, 0, 0, 0, 1, 0, 4'b0101);
    add("lt01",     0, 1, 0, 1, 0, 1, 0, 4'b0011);
    add("gt10",     0, 1, 1, 0, 0, 1, 0, 4'b1001);
    add("eq11",     0, 1, 1, 1, 0, 1, 0, 4'b0101);
    add("casc_gt",  0, 1, 0, 1, 1, 0, 0, 4'b1001);
    add("casc_lt",  0, 1, 1, 0, 0, 0, 1, 4'b0011);
    add("casc_both",0, 1, 0, 0, 1, 0, 1, 4'b1001);
    add("casc_none",0, 1, 0, 1, 0, 0, 0, 4'b0011);
    add("hold_set", 0, 1, 1, 0, 0, 1, 0, 4'b1001);
    add("hold1",    0, 0, 0, 1, 0, 1, 0, 4'b1000);
    add("hold2",    0, 0, 1, 1, 0, 0, 1, 4'b1000);
    add("hold3",    0, 0, 0, 0, 1, 1, 1, 4'b1000);
    add("mid_rst",  1, 1, 0, 1, 0, 1, 0, 4'b0000);
    add("post_rst", 0, 0, 0, 1, 0, 1, 0, 4'b0000);

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].b,
            tbl[i].cg, tbl[i].ce, tbl[i].cl);
      check(tbl[i].name, tbl[i].exp);
    end

`ifdef CMP_STATS_EN
    apply(1, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) apply(0, 1, 1, 1, 0, 1, 0);
    check_cnt("sat_eq", int'(eq_cnt), 3);
    check_cnt("sat_gt", int'(gt_cnt), 0);
    check_cnt("sat_lt", int'(lt_cnt), 0);
    apply(1, 0, 0, 0, 0, 1, 0);
    check_cnt("clr_eq", int'(eq_cnt), 0);
    check_cnt("clr_gt", int'(gt_cnt), 0);
    check_cnt("clr_lt", int'(lt_cnt), 0);
`endif

    apply(1, 0, 0, 0, 0, 1, 0);
    m_res = 0; m_val = 0;
    for (int c = 0; c < 4; c++) m_cnt[c] = 0;
    for (int n = 0; n < 400; n++) begin
      logic r, v, a, b, cg, ce, cl;
      int res;
      r  = ($urandom_range(15) == 0);
      v  = ($urandom_range(3) != 0);
      a  = 1'($urandom_range(1));
      b  = 1'($urandom_range(1));
      cg = ($urandom_range(4) == 0);
      cl = ($urandom_range(4) == 0);
      ce = 1'($urandom_range(1));
      apply(r, v, a, b, cg, ce, cl);
      if (r) begin
        m_res = 0; m_val = 0;
        for (int c = 0; c < 4; c++) m_cnt[c] = 0;
      end else if (v) begin
        res = resolve(a, b, cg, cl);
        m_res = res; m_val = 1;
        if (m_cnt[res] < (1 << CNT_W) - 1) m_cnt[res]++;
      end else begin
        m_val = 0;
      end
      check($sformatf("rand%0d", n), model_out());
`ifdef CMP_STATS_EN
      check_cnt($sformatf("rand_gt%0d", n), int'(gt_cnt), m_cnt[3]);
      check_cnt($sformatf("rand_eq%0d", n), int'(eq_cnt), m_cnt[2]);
      check_cnt($sformatf("rand_lt%0d", n), int'(lt_cnt), m_cnt[1]);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
